// File: rtl/window_monitor_pkg.sv
// Shared definitions for the window monitor: default geometry and alarm FSM encoding.
package window_monitor_pkg;

  localparam int WM_WIDTH = 10;
  localparam int WM_HOLD  = 4;
  localparam int WM_CNT_W = 16;

  typedef enum logic {
    ST_OK    = 1'b0,
    ST_ALARM = 1'b1
  } alarm_state_e;

  // Run counter must hold values 0..hold inclusive.
  function automatic int run_width(input int hold);
    return (hold < 1) ? 1 : $clog2(hold + 1);
  endfunction

endpackage

// File: rtl/window_monitor_compare.sv
// Combinational classifier: window compare of one sample plus running min/max selection.
module window_compare
  import window_monitor_pkg::*;
#(
  parameter int WIDTH = WM_WIDTH
) (
  input  logic [WIDTH-1:0] x_i,
  input  logic [WIDTH-1:0] lo_i,
  input  logic [WIDTH-1:0] hi_i,
  input  logic [WIDTH-1:0] min_i,
  input  logic [WIDTH-1:0] max_i,
  input  logic             first_i,
  output logic             below_o,
  output logic             above_o,
  output logic             inwin_o,
  output logic [WIDTH-1:0] min_o,
  output logic [WIDTH-1:0] max_o
);

  // Window classification; with lo > hi a sample can be both below and above.
  always_comb begin
    below_o = (x_i < lo_i);
    above_o = (x_i > hi_i);
    inwin_o = !below_o && !above_o;
  end

  // First sample of an epoch seeds both extremes.
  always_comb begin
    if (first_i) begin
      min_o = x_i;
      max_o = x_i;
    end else begin
      min_o = (x_i < min_i) ? x_i : min_i;
      max_o = (x_i > max_i) ? x_i : max_i;
    end
  end

endmodule

// File: rtl/window_monitor.sv
// Window monitor top: 1-deep result register, epoch min/max/count and debounced alarm FSM.
module window_monitor
  import window_monitor_pkg::*;
#(
  parameter int WIDTH = WM_WIDTH,
  parameter int HOLD  = WM_HOLD,
  parameter int CNT_W = WM_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic [WIDTH-1:0] lo,
  input  logic [WIDTH-1:0] hi,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_below,
  output logic             out_above,
  output logic             out_inwin,
  output logic [WIDTH-1:0] out_min,
  output logic [WIDTH-1:0] out_max,
  output logic [CNT_W-1:0] out_count,
  output logic             alarm
);

  localparam int               R_W     = run_width(HOLD);
  localparam logic [R_W:0]     HOLD_V  = (R_W + 1)'(HOLD);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic             out_valid_q, out_valid_d;
  logic             below_q, below_d;
  logic             above_q, above_d;
  logic             inwin_q, inwin_d;
  logic [WIDTH-1:0] min_q, min_d;
  logic [WIDTH-1:0] max_q, max_d;
  logic [CNT_W-1:0] count_q, count_d;

  logic             have_q, have_d;
  logic [WIDTH-1:0] emin_q, emin_d;
  logic [WIDTH-1:0] emax_q, emax_d;
  logic [CNT_W-1:0] ecount_q, ecount_d;

  alarm_state_e     state_q, state_d, state_base_s;
  logic [R_W-1:0]   run_q, run_d, run_base_s;
  logic [R_W:0]     run_inc_s;

  logic             accept_s;
  logic             first_s;
  logic             cmp_below_s, cmp_above_s, cmp_inwin_s;
  logic [WIDTH-1:0] cmp_min_s, cmp_max_s;

  assign in_ready = !out_valid_q || out_ready;
  assign accept_s = in_valid && in_ready;
  assign first_s  = clear || !have_q;

  window_compare #(.WIDTH(WIDTH)) u_cmp (
    .x_i     (in_data),
    .lo_i    (lo),
    .hi_i    (hi),
    .min_i   (emin_q),
    .max_i   (emax_q),
    .first_i (first_s),
    .below_o (cmp_below_s),
    .above_o (cmp_above_s),
    .inwin_o (cmp_inwin_s),
    .min_o   (cmp_min_s),
    .max_o   (cmp_max_s)
  );

  // Epoch bookkeeping; an accepted sample with clear starts the new epoch.
  always_comb begin
    have_d   = have_q;
    emin_d   = emin_q;
    emax_d   = emax_q;
    ecount_d = ecount_q;
    if (accept_s) begin
      have_d = 1'b1;
      emin_d = cmp_min_s;
      emax_d = cmp_max_s;
      if (first_s) begin
        ecount_d = CNT_W'(1);
      end else if (ecount_q == CNT_MAX) begin
        ecount_d = ecount_q;
      end else begin
        ecount_d = ecount_q + CNT_W'(1);
      end
    end else if (clear) begin
      have_d   = 1'b0;
      emin_d   = '0;
      emax_d   = '0;
      ecount_d = '0;
    end else begin
      have_d = have_q;
    end
  end

  // Alarm FSM next state: counts consecutive samples that disagree with the current state.
  always_comb begin
    state_base_s = clear ? ST_OK : state_q;
    run_base_s   = clear ? '0 : run_q;
    run_inc_s    = {1'b0, run_base_s} + (R_W + 1)'(1);
    state_d      = state_base_s;
    run_d        = run_base_s;
    if (accept_s) begin
      case (state_base_s)
        ST_OK: begin
          if (!cmp_inwin_s) begin
            if (run_inc_s == HOLD_V) begin
              state_d = ST_ALARM;
              run_d   = '0;
            end else begin
              run_d = run_inc_s[R_W-1:0];
            end
          end else begin
            run_d = '0;
          end
        end
        ST_ALARM: begin
          if (cmp_inwin_s) begin
            if (run_inc_s == HOLD_V) begin
              state_d = ST_OK;
              run_d   = '0;
            end else begin
              run_d = run_inc_s[R_W-1:0];
            end
          end else begin
            run_d = '0;
          end
        end
        default: begin
          state_d = ST_OK;
          run_d   = '0;
        end
      endcase
    end else begin
      run_d = run_base_s;
    end
  end

  // Result beat: load on accept, drop when consumed, otherwise hold.
  always_comb begin
    out_valid_d = out_valid_q;
    below_d     = below_q;
    above_d     = above_q;
    inwin_d     = inwin_q;
    min_d       = min_q;
    max_d       = max_q;
    count_d     = count_q;
    if (accept_s) begin
      out_valid_d = 1'b1;
      below_d     = cmp_below_s;
      above_d     = cmp_above_s;
      inwin_d     = cmp_inwin_s;
      min_d       = cmp_min_s;
      max_d       = cmp_max_s;
      count_d     = ecount_d;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end else begin
      out_valid_d = out_valid_q;
    end
  end

  // State registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      below_q     <= 1'b0;
      above_q     <= 1'b0;
      inwin_q     <= 1'b0;
      min_q       <= '0;
      max_q       <= '0;
      count_q     <= '0;
      have_q      <= 1'b0;
      emin_q      <= '0;
      emax_q      <= '0;
      ecount_q    <= '0;
      state_q     <= ST_OK;
      run_q       <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      below_q     <= below_d;
      above_q     <= above_d;
      inwin_q     <= inwin_d;
      min_q       <= min_d;
      max_q       <= max_d;
      count_q     <= count_d;
      have_q      <= have_d;
      emin_q      <= emin_d;
      emax_q      <= emax_d;
      ecount_q    <= ecount_d;
      state_q     <= state_d;
      run_q       <= run_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_below = below_q;
  assign out_above = above_q;
  assign out_inwin = inwin_q;
  assign out_min   = min_q;
  assign out_max   = max_q;
  assign out_count = count_q;
  assign alarm     = (state_q == ST_ALARM);

endmodule

// File: tb/tb_window_monitor.sv
// Scoreboard bench for window_monitor: directed samples with hand-computed expected beats.
module tb_window_monitor;

  typedef struct {
    logic        below;
    logic        above;
    logic        inwin;
    logic [9:0]  mn;
    logic [9:0]  mx;
    logic [15:0] cnt;
    logic        alm;
  } beat_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        clear = 1'b0;
  logic [9:0]  lo = 10'd0;
  logic [9:0]  hi = 10'd0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [9:0]  in_data = 10'd0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic        out_below;
  logic        out_above;
  logic        out_inwin;
  logic [9:0]  out_min;
  logic [9:0]  out_max;
  logic [15:0] out_count;
  logic        alarm;

  beat_t exp_q[$];
  beat_t mon_e;
  int    checks = 0;
  int    errors = 0;

  window_monitor #(.WIDTH(10), .HOLD(4), .CNT_W(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (clear),
    .lo        (lo),
    .hi        (hi),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_below (out_below),
    .out_above (out_above),
    .out_inwin (out_inwin),
    .out_min   (out_min),
    .out_max   (out_max),
    .out_count (out_count),
    .alarm     (alarm)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic compare_beat(input beat_t e);
    check("beat_below", 32'(out_below), 32'(e.below));
    check("beat_above", 32'(out_above), 32'(e.above));
    check("beat_inwin", 32'(out_inwin), 32'(e.inwin));
    check("beat_min",   32'(out_min),   32'(e.mn));
    check("beat_max",   32'(out_max),   32'(e.mx));
    check("beat_count", 32'(out_count), 32'(e.cnt));
    check("beat_alarm", 32'(alarm),     32'(e.alm));
  endtask

  // Monitor: every beat that is about to be consumed is checked against the scoreboard.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_beat actual=count %0d required=no beat", out_count);
      end else begin
        mon_e = exp_q.pop_front();
        compare_beat(mon_e);
      end
    end
  end

  task automatic send(input logic [9:0] x, input logic [9:0] lo_v, input logic [9:0] hi_v,
                      input logic clr, input logic b, input logic a,
                      input logic [9:0] mn, input logic [9:0] mx,
                      input logic [15:0] cnt, input logic alm);
    beat_t e;
    int    n;
    in_data  = x;
    lo       = lo_v;
    hi       = hi_v;
    clear    = clr;
    in_valid = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!in_ready && n < 50);
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout actual=in_ready 0 required=1 sample=%0d", x);
    end else begin
      e.below = b;
      e.above = a;
      e.inwin = !b && !a;
      e.mn    = mn;
      e.mx    = mx;
      e.cnt   = cnt;
      e.alm   = alm;
      exp_q.push_back(e);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    clear    = 1'b0;
  endtask

  task automatic drain();
    repeat (3) @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1);
  end

  initial begin
    // Reset state
    #2;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_in_ready",  32'(in_ready),  32'd1);
    check("rst_alarm",     32'(alarm),     32'd0);
    check("rst_count",     32'(out_count), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    @(posedge clk);
    #1;

    // In-window samples including both inclusive bounds
    send(10'd150, 10'd100, 10'd200, 1'b0, 1'b0, 1'b0, 10'd150, 10'd150, 16'd1, 1'b0);
    send(10'd100, 10'd100, 10'd200, 1'b0, 1'b0, 1'b0, 10'd100, 10'd150, 16'd2, 1'b0);
    send(10'd200, 10'd100, 10'd200, 1'b0, 1'b0, 1'b0, 10'd100, 10'd200, 16'd3, 1'b0);

    // Four out-of-window raise alarm; four in-window clear it
    send(10'd50,  10'd100, 10'd200, 1'b0, 1'b1, 1'b0, 10'd50, 10'd200, 16'd4, 1'b0);
    send(10'd250, 10'd100, 10'd200, 1'b0, 1'b0, 1'b1, 10'd50, 10'd250, 16'd5, 1'b0);
    send(10'd99,  10'd100, 10'd200, 1'b0, 1'b1, 1'b0, 10'd50, 10'd250, 16'd6, 1'b0);
    send(10'd201, 10'd100, 10'd200, 1'b0, 1'b0, 1'b1, 10'd50, 10'd250, 16'd7, 1'b1);
    send(10'd150, 10'd100, 10'd200, 1'b0, 1'b0, 1'b0, 10'd50, 10'd250, 16'd8, 1'b1);
    send(10'd150, 10'd100, 10'd200, 1'b0, 1'b0, 1'b0, 10'd50, 10'd250, 16'd9, 1'b1);
    send(10'd150, 10'd100, 10'd200, 1'b0, 1'b0, 1'b0, 10'd50, 10'd250, 16'd10, 1'b1);
    send(10'd150, 10'd100, 10'd200, 1'b0, 1'b0, 1'b0, 10'd50, 10'd250, 16'd11, 1'b0);

    // Interrupted run of out-of-window samples never raises alarm
    send(10'd10,  10'd100, 10'd200, 1'b0, 1'b1, 1'b0, 10'd10, 10'd250, 16'd12, 1'b0);
    send(10'd300, 10'd100, 10'd200, 1'b0, 1'b0, 1'b1, 10'd10, 10'd300, 16'd13, 1'b0);
    send(10'd20,  10'd100, 10'd200, 1'b0, 1'b1, 1'b0, 10'd10, 10'd300, 16'd14, 1'b0);
    send(10'd150, 10'd100, 10'd200, 1'b0, 1'b0, 1'b0, 10'd10, 10'd300, 16'd15, 1'b0);
    send(10'd400, 10'd100, 10'd200, 1'b0, 1'b0, 1'b1, 10'd10, 10'd400, 16'd16, 1'b0);
    send(10'd5,   10'd100, 10'd200, 1'b0, 1'b1, 1'b0, 10'd5,  10'd400, 16'd17, 1'b0);
    send(10'd500, 10'd100, 10'd200, 1'b0, 1'b0, 1'b1, 10'd5,  10'd500, 16'd18, 1'b0);
    drain();

    // Backpressure: one beat held stable, next sample waits
    out_ready = 1'b0;
    send(10'd123, 10'd100, 10'd200, 1'b0, 1'b0, 1'b0, 10'd5, 10'd500, 16'd19, 1'b0);
    in_data  = 10'd124;
    in_valid = 1'b1;
    repeat (5) begin
      @(negedge clk);
      check("stall_out_valid", 32'(out_valid), 32'd1);
      check("stall_in_ready",  32'(in_ready),  32'd0);
      check("stall_count",     32'(out_count), 32'(exp_q[0].cnt));
      check("stall_max",       32'(out_max),   32'(exp_q[0].mx));
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    send(10'd124, 10'd100, 10'd200, 1'b0, 1'b0, 1'b0, 10'd5, 10'd500, 16'd20, 1'b0);
    drain();

    // Clear with accept starts a new epoch; inverted window marks both flags
    send(10'd7,   10'd100, 10'd200, 1'b1, 1'b1, 1'b0, 10'd7, 10'd7,   16'd1, 1'b0);
    send(10'd50,  10'd300, 10'd10,  1'b0, 1'b1, 1'b1, 10'd7, 10'd50,  16'd2, 1'b0);
    send(10'd400, 10'd300, 10'd10,  1'b0, 1'b0, 1'b1, 10'd7, 10'd400, 16'd3, 1'b0);
    send(10'd5,   10'd300, 10'd10,  1'b0, 1'b1, 1'b0, 10'd5, 10'd400, 16'd4, 1'b1);
    drain();

    // Clear alone drops alarm and empties the epoch
    clear = 1'b1;
    @(posedge clk);
    #1;
    clear = 1'b0;
    @(negedge clk);
    check("clear_alarm",     32'(alarm),     32'd0);
    check("clear_out_valid", 32'(out_valid), 32'd0);
    @(posedge clk);
    #1;
    send(10'd200, 10'd300, 10'd10,  1'b0, 1'b1, 1'b1, 10'd200, 10'd200, 16'd1, 1'b0);
    send(10'd300, 10'd100, 10'd200, 1'b0, 1'b0, 1'b1, 10'd200, 10'd300, 16'd2, 1'b0);
    send(10'd301, 10'd100, 10'd200, 1'b0, 1'b0, 1'b1, 10'd200, 10'd301, 16'd3, 1'b0);
    send(10'd302, 10'd100, 10'd200, 1'b0, 1'b0, 1'b1, 10'd200, 10'd302, 16'd4, 1'b1);
    drain();

    // Async reset with a pending beat and alarm set
    out_ready = 1'b0;
    send(10'd303, 10'd100, 10'd200, 1'b0, 1'b0, 1'b1, 10'd200, 10'd303, 16'd5, 1'b1);
    #3;
    rst_n = 1'b0;
    #1;
    check("mid_rst_out_valid", 32'(out_valid), 32'd0);
    check("mid_rst_alarm",     32'(alarm),     32'd0);
    check("mid_rst_in_ready",  32'(in_ready),  32'd1);
    check("mid_rst_count",     32'(out_count), 32'd0);
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    send(10'd42, 10'd100, 10'd200, 1'b0, 1'b1, 1'b0, 10'd42, 10'd42, 16'd1, 1'b0);
    drain();

    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
